// File: rtl/regwr_arbiter_pkg.sv
// rtl/regwr_arbiter_pkg.sv - shared constants and helpers for the register-write arbiter
// Purpose : requester count, requester indices, address width, pointer type and
//           the round-robin pointer advance helper.
// Ports   : none (package).
package regwr_arbiter_pkg;

   localparam int NREQ     = 3;
   localparam int ADDR_W   = 3;

   localparam int REQ_ALU  = 0;
   localparam int REQ_LOAD = 1;
   localparam int REQ_IMM  = 2;

   typedef logic [1:0] ptr_t;

   // Pointer after a grant to requester k: (k+1) mod NREQ.
   function automatic ptr_t next_ptr(input ptr_t k);
      return (k == ptr_t'(NREQ - 1)) ? ptr_t'(0) : ptr_t'(k + ptr_t'(1));
   endfunction

endpackage

// File: rtl/regwr_arbiter_if.sv
// rtl/regwr_arbiter_if.sv - requester/register-file bus of the register-write arbiter
// Purpose : bundles the three request channels and the shared write port.
// Ports   : i_req, i_addr0..2, i_data0..2 (requester -> arbiter);
//           o_we, o_D, o_ack, o_busy (arbiter -> requesters / register file).
//           master = requester side, slave = arbiter side.
interface regwr_arbiter_if #(
   parameter int WIDTH = 8,
   parameter int NREG  = 8
);
   import regwr_arbiter_pkg::*;

   logic [NREQ-1:0]   i_req;
   logic [ADDR_W-1:0] i_addr0;
   logic [ADDR_W-1:0] i_addr1;
   logic [ADDR_W-1:0] i_addr2;
   logic [WIDTH-1:0]  i_data0;
   logic [WIDTH-1:0]  i_data1;
   logic [WIDTH-1:0]  i_data2;
   logic [NREG-1:0]   o_we;
   logic [WIDTH-1:0]  o_D;
   logic [NREQ-1:0]   o_ack;
   logic              o_busy;

   modport master (
      output i_req, i_addr0, i_addr1, i_addr2, i_data0, i_data1, i_data2,
      input  o_we, o_D, o_ack, o_busy
   );

   modport slave (
      input  i_req, i_addr0, i_addr1, i_addr2, i_data0, i_data1, i_data2,
      output o_we, o_D, o_ack, o_busy
   );

endinterface

// File: rtl/regwr_arbiter_rr_pick.sv
// rtl/regwr_arbiter_rr_pick.sv - combinational round-robin picker
// Purpose : picks the first eligible requester searching p, p+1, p+2 (mod NREQ).
// Ports   : i_elig  eligible mask
//           i_ptr   index searched first
//           o_gnt   one-hot grant
//           o_valid high when some requester was picked
module rr_pick
   import regwr_arbiter_pkg::*;
(
   input  logic [NREQ-1:0] i_elig,
   input  ptr_t            i_ptr,
   output logic [NREQ-1:0] o_gnt,
   output logic            o_valid
);

   ptr_t idx;

   always_comb begin
      o_gnt   = '0;
      o_valid = 1'b0;
      idx     = '0;
      for (int s = 0; s < NREQ; s++) begin
         idx = ptr_t'((int'(i_ptr) + s) % NREQ);
         if (!o_valid && i_elig[idx]) begin
            o_gnt[idx] = 1'b1;
            o_valid    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/regwr_arbiter.sv
// rtl/regwr_arbiter.sv - round-robin arbiter for the shared register-file write port
// Purpose : grants one of three requesters per cycle and drives the write port.
// Ports   : i_clk    clock, rising edge
//           i_rst_n  synchronous active-low reset
//           bus      slave modport: i_req/i_addrK/i_dataK in; o_we/o_D/o_ack/o_busy out
module regwr_arbiter
   import regwr_arbiter_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int NREG  = 8
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   regwr_arbiter_if.slave  bus
);

   logic [NREG-1:0]   we_q,   we_d;
   logic [WIDTH-1:0]  d_q,    d_d;
   logic [NREQ-1:0]   ack_q,  ack_d;
   logic              busy_q, busy_d;
   ptr_t              ptr_q,  ptr_d;

   logic [NREQ-1:0]   elig;
   logic [NREQ-1:0]   gnt;
   logic              gnt_valid;
   ptr_t              gnt_idx;
   logic [ADDR_W-1:0] sel_addr;
   logic [WIDTH-1:0]  sel_data;

   // A requester being acked this cycle still holds i_req high; masking it
   // keeps the same request from being granted twice.
   assign elig = bus.i_req & ~ack_q;

   rr_pick u_pick (
      .i_elig  (elig),
      .i_ptr   (ptr_q),
      .o_gnt   (gnt),
      .o_valid (gnt_valid)
   );

   always_comb begin
      gnt_idx  = ptr_t'(REQ_ALU);
      sel_addr = bus.i_addr0;
      sel_data = bus.i_data0;
      if (gnt[REQ_LOAD]) begin
         gnt_idx  = ptr_t'(REQ_LOAD);
         sel_addr = bus.i_addr1;
         sel_data = bus.i_data1;
      end
      if (gnt[REQ_IMM]) begin
         gnt_idx  = ptr_t'(REQ_IMM);
         sel_addr = bus.i_addr2;
         sel_data = bus.i_data2;
      end
   end

   always_comb begin
      we_d   = '0;
      ack_d  = '0;
      busy_d = 1'b0;
      d_d    = d_q;
      ptr_d  = ptr_q;
      if (gnt_valid) begin
         ack_d  = gnt;
         busy_d = 1'b1;
         d_d    = sel_data;
         ptr_d  = next_ptr(gnt_idx);
         // Out-of-range target: the grant is still acked, the write is dropped.
         if (int'(sel_addr) < NREG) begin
            we_d[sel_addr] = 1'b1;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         we_q   <= '0;
         d_q    <= '0;
         ack_q  <= '0;
         busy_q <= 1'b0;
         ptr_q  <= '0;
      end else begin
         we_q   <= we_d;
         d_q    <= d_d;
         ack_q  <= ack_d;
         busy_q <= busy_d;
         ptr_q  <= ptr_d;
      end
   end

   assign bus.o_we   = we_q;
   assign bus.o_D    = d_q;
   assign bus.o_ack  = ack_q;
   assign bus.o_busy = busy_q;

endmodule

// File: tb/tb_regwr_arbiter.sv
// tb/tb_regwr_arbiter.sv - self-checking bench for regwr_arbiter
module tb_regwr_arbiter;
   import regwr_arbiter_pkg::*;

   localparam int W  = 8;
   localparam int NR = 6;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   regwr_arbiter_if #(.WIDTH(W), .NREG(NR)) bus ();

   regwr_arbiter #(.WIDTH(W), .NREG(NR)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
   );

   typedef struct packed {
      logic [NR-1:0] we;
      logic [W-1:0]  d;
      logic [2:0]    ack;
      logic          busy;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   // Register file fed by the arbiter write port.
   logic [W-1:0] regs [NR] = '{default: '0};
   always @(posedge clk) begin
      for (int i = 0; i < NR; i++) if (bus.o_we[i]) regs[i] <= bus.o_D;
   end

   // Reference model state.
   int         m_ptr = 0;
   logic [2:0] m_ack = '0;
   logic [W-1:0] m_d = '0;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic predict(output exp_t e);
      logic [2:0]   elig;
      logic [2:0]   a;
      logic [W-1:0] dv;
      int           win;
      e.we   = '0;
      e.ack  = '0;
      e.busy = 1'b0;
      e.d    = m_d;
      win    = -1;
      if (!rst_n) begin
         e.d   = '0;
         m_ptr = 0;
         m_ack = '0;
         m_d   = '0;
      end else begin
         elig = bus.i_req & ~m_ack;
         for (int s = 0; s < 3; s++) begin
            if (win < 0 && elig[(m_ptr + s) % 3]) win = (m_ptr + s) % 3;
         end
         if (win >= 0) begin
            case (win)
               0:       begin a = bus.i_addr0; dv = bus.i_data0; end
               1:       begin a = bus.i_addr1; dv = bus.i_data1; end
               default: begin a = bus.i_addr2; dv = bus.i_data2; end
            endcase
            e.ack[win] = 1'b1;
            e.busy     = 1'b1;
            e.d        = dv;
            if (int'(a) < NR) e.we[a] = 1'b1;
            m_ptr = (win + 1) % 3;
         end
         m_ack = e.ack;
         m_d   = e.d;
      end
   endtask

   task automatic step();
      exp_t e;
      predict(e);
      sb.push_back(e);
      @(posedge clk);
      @(negedge clk);
      e = sb.pop_front();
      check_eq("sb_ack",  32'(bus.o_ack),  32'(e.ack));
      check_eq("sb_we",   32'(bus.o_we),   32'(e.we));
      check_eq("sb_d",    32'(bus.o_D),    32'(e.d));
      check_eq("sb_busy", 32'(bus.o_busy), 32'(e.busy));
   endtask

   task automatic drive(input int k, input logic on, input logic [2:0] a, input logic [W-1:0] d);
      case (k)
         0:       begin bus.i_req[0] = on; bus.i_addr0 = a; bus.i_data0 = d; end
         1:       begin bus.i_req[1] = on; bus.i_addr1 = a; bus.i_data1 = d; end
         default: begin bus.i_req[2] = on; bus.i_addr2 = a; bus.i_data2 = d; end
      endcase
   endtask

   task automatic drop_acked();
      for (int k = 0; k < 3; k++) if (bus.o_ack[k]) bus.i_req[k] = 1'b0;
   endtask

   task automatic do_reset();
      bus.i_req = '0;
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
   endtask

   logic [2:0] acks [8];
   int         cnt;

   initial begin
      bus.i_req = '0;
      bus.i_addr0 = '0; bus.i_addr1 = '0; bus.i_addr2 = '0;
      bus.i_data0 = '0; bus.i_data1 = '0; bus.i_data2 = '0;

      // Reset with all requesters active.
      bus.i_req = 3'b111;
      step();
      check_eq("rst_we",   32'(bus.o_we),   0);
      check_eq("rst_ack",  32'(bus.o_ack),  0);
      check_eq("rst_d",    32'(bus.o_D),    0);
      check_eq("rst_busy", 32'(bus.o_busy), 0);
      rst_n = 1'b1;
      bus.i_req = '0;

      // Single write.
      drive(0, 1'b1, 3'd3, 8'h5A);
      step();
      check_eq("single_we",  32'(bus.o_we),  32'h08);
      check_eq("single_d",   32'(bus.o_D),   32'h5A);
      check_eq("single_ack", 32'(bus.o_ack), 32'h1);
      drop_acked();
      step();
      check_eq("single_reg3", 32'(regs[3]), 32'h5A);
      check_eq("hold_d",      32'(bus.o_D), 32'h5A);

      // Contention from reset.
      do_reset();
      drive(0, 1'b1, 3'd0, 8'hA0);
      drive(1, 1'b1, 3'd1, 8'hA1);
      drive(2, 1'b1, 3'd2, 8'hA2);
      for (int i = 0; i < 3; i++) begin
         step();
         acks[i] = bus.o_ack;
         drop_acked();
      end
      check_eq("cont_ack0", 32'(acks[0]), 32'h1);
      check_eq("cont_ack1", 32'(acks[1]), 32'h2);
      check_eq("cont_ack2", 32'(acks[2]), 32'h4);
      step();
      check_eq("cont_reg2", 32'(regs[2]), 32'hA2);

      // Fairness between 0 and 2, then 1 joins after a grant to 0.
      do_reset();
      drive(0, 1'b1, 3'd0, 8'hB0);
      drive(2, 1'b1, 3'd2, 8'hB2);
      for (int i = 0; i < 5; i++) begin
         step();
         acks[i] = bus.o_ack;
      end
      check_eq("fair_g0", 32'(acks[0]), 32'h1);
      check_eq("fair_g1", 32'(acks[1]), 32'h4);
      check_eq("fair_g2", 32'(acks[2]), 32'h1);
      check_eq("fair_g3", 32'(acks[3]), 32'h4);
      check_eq("fair_g4", 32'(acks[4]), 32'h1);
      drive(1, 1'b1, 3'd1, 8'hC1);
      step();
      check_eq("join_ack", 32'(bus.o_ack), 32'h2);
      bus.i_req = '0;
      step();

      // Single continuous requester: grant every second cycle.
      do_reset();
      drive(0, 1'b1, 3'd0, 8'hD0);
      cnt = 0;
      for (int i = 0; i < 4; i++) begin
         step();
         if (bus.o_ack[0]) cnt++;
      end
      check_eq("b2b_grants", 32'(cnt), 32'd2);
      bus.i_req = '0;
      step();

      // Same-address collision.
      do_reset();
      drive(0, 1'b1, 3'd5, 8'h11);
      drive(1, 1'b1, 3'd5, 8'h22);
      for (int i = 0; i < 4; i++) begin
         step();
         drop_acked();
      end
      check_eq("coll_reg5", 32'(regs[5]), 32'h22);

      // Out-of-range targets: acked, no write enable.
      for (int a = NR; a < 8; a++) begin
         drive(2, 1'b1, 3'(a), 8'(8'h30 + a));
         step();
         check_eq("oor_ack", 32'(bus.o_ack), 32'h4);
         check_eq("oor_we",  32'(bus.o_we),  0);
         drop_acked();
         step();
      end

      // Requester 1 drops before being granted.
      do_reset();
      drive(0, 1'b1, 3'd0, 8'hE0);
      drive(1, 1'b1, 3'd4, 8'h77);
      step();
      check_eq("drop_ack0", 32'(bus.o_ack), 32'h1);
      bus.i_req = '0;
      step();
      check_eq("drop_noack", 32'(bus.o_ack), 0);
      step();
      check_eq("drop_reg4", 32'(regs[4]), 0);

      // Reset while a request is pending, with the pointer moved off 0.
      drive(1, 1'b1, 3'd1, 8'hF1);
      step();
      drop_acked();
      step();
      drive(2, 1'b1, 3'd4, 8'h99);
      rst_n = 1'b0;
      step();
      check_eq("rmid_ack", 32'(bus.o_ack), 0);
      rst_n = 1'b1;
      bus.i_req = '0;
      step();
      step();
      check_eq("rmid_reg4", 32'(regs[4]), 0);
      drive(0, 1'b1, 3'd0, 8'h90);
      drive(1, 1'b1, 3'd1, 8'h91);
      drive(2, 1'b1, 3'd2, 8'h92);
      step();
      check_eq("rmid_ptr0", 32'(bus.o_ack), 32'h1);
      for (int i = 0; i < 3; i++) begin
         drop_acked();
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/regwr_arbiter.md
REGWR_ARBITER -- requirements
Module: regwr_arbiter

Interface
REQ-001 Parameter WIDTH, default 8, data width of the shared register-file write port.
REQ-002 Parameter NREG, default 8, number of Register instances driven; address width is 3 at default.
REQ-003 i_clk  input  1  single clock; all state updates on rising edge.
REQ-004 i_rst_n  input  1  reset, synchronous, active-low.
REQ-005 i_req  input  3  per-requester write request (bit0 ALU, bit1 load, bit2 immediate).
REQ-006 i_addr0, i_addr1, i_addr2  input  3 each  target register index per requester.
REQ-007 i_data0, i_data1, i_data2  input  WIDTH each  write data per requester.
REQ-008 o_we  output  NREG  one-hot write enable to Register i_we pins, registered.
REQ-009 o_D  output  WIDTH  shared write data to all Register i_D pins, registered.
REQ-010 o_ack  output  3  one-hot, one-cycle completion pulse to the granted requester, registered.
REQ-011 o_busy  output  1  registered; high in any cycle where o_we is non-zero.

Function
REQ-012 Handshake: requester raises i_req[k] with stable addr/data, holds all three until it samples o_ack[k]=1, then may drop or re-issue.
REQ-013 At each edge the arbiter grants at most one eligible requester; eligible = i_req[k]=1 and o_ack[k]=0 in the current cycle.
REQ-014 Grant latency: request sampled at edge N drives o_we/o_D/o_ack during cycle N+1; Register captures data at edge N+2.
REQ-015 o_we, o_ack and o_busy are asserted for exactly one cycle per grant; zero when no grant.
REQ-016 Round-robin: pointer holds the index searched first; after a grant to k, pointer becomes (k+1) mod 3; pointer unchanged when no grant.
REQ-017 Search order from pointer p: p, p+1, p+2 (mod 3); first eligible wins.
REQ-018 o_we bit i_addrk asserted only; address >= NREG yields o_we=0 but o_ack[k] still pulses (write dropped).
REQ-019 o_D holds the granted data during the grant cycle; otherwise o_D holds its last value.
REQ-020 Same-address requests from different requesters are serialised in grant order; last granted value persists.
REQ-021 Requester dropping i_req before ack: never granted, no ack; no partial writes.
REQ-022 Back-to-back: a single requester continuously requesting gets a grant every second cycle at most (ack-mask rule REQ-013); two or more continuous requesters yield a grant every cycle.

Reset
REQ-023 When i_rst_n=0 at an edge: o_we=0, o_ack=0, o_busy=0, o_D=0, pointer=0.
REQ-024 Reset during a grant cycle cancels any write not yet captured; no ack is issued for it; requesters re-issue.
REQ-025 First edge with i_rst_n=1 arbitrates normally from pointer 0.

Structure
REQ-026 Requester count (3), requester index constants and address width belong in a shared package.
REQ-027 Round-robin selection is a combinational sub-module rr_pick (inputs: eligible mask, pointer; outputs: one-hot grant, valid).
REQ-028 All outputs come directly from flip-flops; no combinational path input-to-output.
REQ-029 Implementation 120-400 lines RTL total including rr_pick.

Verification
REQ-030 Reset: hold i_rst_n=0 one edge with i_req=3'b111 -> o_we=0, o_ack=0, o_D=0 next cycle.
REQ-031 Single write: i_req=3'b001, i_addr0=3, i_data0=8'h5A -> next cycle o_we=8'b00001000, o_D=8'h5A, o_ack=3'b001; Register 3 reads 8'h5A one edge later.
REQ-032 Contention: i_req=3'b111 from reset, each held until ack -> acks 001, 010, 100 on three consecutive cycles.
REQ-033 Fairness: requester 0 and 2 held permanently with re-issue -> grants alternate 0,2,0,2; requester 1 joining after a grant to 0 is granted next.
REQ-034 Collision: req0 addr 5 data 8'h11 and req1 addr 5 data 8'h22 together -> register 5 ends at 8'h22.
REQ-035 Reset mid-operation: assert i_rst_n=0 at the edge following a sampled request -> no o_ack, target register unchanged, pointer 0.
